// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS/CTRL bit positions and the transmit state encoding.
package wb_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVIDER = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_TX_EN  = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, wrapping pointers and a
// separate occupancy counter so full and empty are unambiguous.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave feeding a TX FIFO that is serialised as 8N1 frames;
// raises a level interrupt once the FIFO and the shifter have both drained.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          req;
  logic          wr;
  logic [15:0]   divider;
  logic          irq_en;
  logic          tx_en;
  logic [31:0]   status_word;
  logic [31:0]   rd_data;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          unused_bits;

  tx_state_t   state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic        tx, tx_n;
  logic        baud_done;

  assign unused_bits = ^{sel_i[3:2], dat_i[31:16]};

  // The !ack_o term inserts the wait state and keeps a held strobe from acking twice in a row.
  assign req  = stb_i & cyc_i & ~ack_o;
  assign wr   = req & we_i;
  assign push = wr & (adr_i == REG_TXDATA) & sel_i[0];
  assign busy = (state != IDLE);

  always_comb begin
    status_word = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = busy;
    status_word[ST_COUNT_LSB +: 4] = 4'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    case (adr_i)
      REG_STATUS:  rd_data = status_word;
      REG_DIVIDER: rd_data = {16'h0000, divider};
      REG_CTRL: begin
        rd_data[CTRL_IRQ_EN] = irq_en;
        rd_data[CTRL_TX_EN]  = tx_en;
      end
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o   <= 1'b0;
      dat_o   <= '0;
      divider <= DIV_RESET;
      irq_en  <= 1'b0;
      tx_en   <= 1'b1;
    end else begin
      ack_o <= req;
      dat_o <= (req & ~we_i) ? rd_data : '0;
      if (wr) begin
        case (adr_i)
          REG_DIVIDER: begin
            if (sel_i[0]) divider[7:0]  <= dat_i[7:0];
            if (sel_i[1]) divider[15:8] <= dat_i[15:8];
          end
          REG_CTRL: begin
            if (sel_i[0]) begin
              irq_en <= dat_i[CTRL_IRQ_EN];
              tx_en  <= dat_i[CTRL_TX_EN];
            end
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_cnt == 16'd0);

  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_en & ~fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          baud_n  = divider;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n    = divider;
          tx_n      = shift[0];
          bit_cnt_n = 3'd0;
          state_n   = DATA;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = divider;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_done) state_n = IDLE;
        else           baud_n  = baud_cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_cnt_n;
      tx       <= tx_n;
    end
  end

  always_ff @(posedge clk_i) begin
    shift <= shift_n;
  end

  assign tx_o  = tx;
  assign irq_o = irq_en & fifo_empty & ~busy;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboarded bench for wb_uart_tx: bus responses and received UART bytes
// are checked by independent monitors against queued expectations.
module tb_wb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } rsp_t;

  rsp_t       rsp_q[$];
  rsp_t       rsp_pop;
  logic [7:0] rx_q[$];
  int         bit_clks = 434;
  int         rst_cnt  = 0;
  logic       prev_ack = 1'b0;
  logic [9:0] rx_f;
  int         rx_rst0;

  always #5 clk = ~clk;

  wb_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .adr_i (adr),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we),
    .sel_i (sel),
    .stb_i (stb),
    .cyc_i (cyc),
    .ack_o (ack),
    .tx_o  (tx),
    .irq_o (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge rst) rst_cnt++;

  // Bus response monitor
  always @(negedge clk) begin
    if (ack) begin
      check("ack_single", {63'b0, prev_ack}, 64'd0);
      if (rsp_q.size() == 0) begin
        check("ack_unexpected", 64'd1, 64'd0);
      end else begin
        rsp_pop = rsp_q.pop_front();
        if (rsp_pop.chk) check("rd_data", {32'b0, dat_o}, {32'b0, rsp_pop.val});
      end
    end else if (prev_ack) begin
      check("dat_idle", {32'b0, dat_o}, 64'd0);
    end
    prev_ack <= ack;
  end

  // UART receiver: samples near mid-bit, discards frames cut by reset
  initial begin
    forever begin
      @(negedge tx);
      if (rst) continue;
      rx_rst0 = rst_cnt;
      repeat (bit_clks / 2) @(negedge clk);
      rx_f[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (bit_clks) @(negedge clk);
        rx_f[i] = tx;
      end
      if (rst_cnt == rx_rst0) begin
        check("rx_start", {63'b0, rx_f[0]}, 64'd0);
        check("rx_stop", {63'b0, rx_f[9]}, 64'd1);
        if (rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got byte %0h expected none", rx_f[8:1]);
        end else begin
          check("rx_byte", {56'b0, rx_f[8:1]}, {56'b0, rx_q.pop_front()});
        end
      end
    end
  end

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input logic chk, input logic [31:0] exp);
    int lat = 0;
    rsp_q.push_back('{chk, exp});
    @(posedge clk); #1;
    adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    check("ack_lat", 64'(lat), 64'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, 1'b1, d, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    bus(a, 1'b0, 32'h0, 4'hF, 1'b1, exp);
  endtask

  initial begin
    int          k;
    logic [39:0] got_bits;
    logic [39:0] exp_bits;
    logic [9:0]  frame;
    logic [5:0]  ack_seq;
    logic        stay;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {63'b0, tx}, 64'd1);
    check("rst_irq", {63'b0, irq}, 64'd0);
    check("rst_ack", {63'b0, ack}, 64'd0);
    check("rst_dat", {32'b0, dat_o}, 64'd0);
    rst = 1'b0;

    // Reset register values
    rd(2'd1, 32'h0000_0002);
    rd(2'd2, 32'h0000_01B1);
    rd(2'd3, 32'h0000_0002);

    // Divider byte lanes
    wr(2'd2, 32'h0000_0003, 4'b0001);
    rd(2'd2, 32'h0000_0103);
    wr(2'd2, 32'h0000_0003, 4'b0011);
    rd(2'd2, 32'h0000_0003);
    bit_clks = 4;

    // Single 0x55 frame with bit-exact waveform and drain interrupt
    wr(2'd3, 32'h0000_0003, 4'b0001);
    rx_q.push_back(8'h55);
    wr(2'd0, 32'h0000_0055, 4'b0001);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) exp_bits[i] = frame[i / 4];
    got_bits = '0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k <= 40) got_bits[k-1] = tx;
    end while (!irq && k < 60);
    check("frame_len", 64'(k), 64'd41);
    check("frame_bits", {24'b0, got_bits}, {24'b0, exp_bits});

    // Overfill with TX disabled, then drain exactly eight bytes
    wr(2'd3, 32'h0000_0001, 4'b0001);
    for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i), 4'b0001);
    rd(2'd1, 32'h0000_0081);
    for (int i = 1; i <= 8; i++) rx_q.push_back(8'(i));
    wr(2'd3, 32'h0000_0003, 4'b0001);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!irq && k < 1000);
    check("drain_irq", {63'b0, irq}, 64'd1);
    check("rx_drained", 64'(rx_q.size()), 64'd0);
    rd(2'd1, 32'h0000_0002);

    // Continuously held strobe: ack every other cycle, three pushes
    wr(2'd3, 32'h0000_0000, 4'b0001);
    for (int i = 0; i < 3; i++) rsp_q.push_back('{1'b0, 32'h0});
    @(posedge clk); #1;
    adr = 2'd0; we = 1'b1; dat_i = 32'h0000_00A5; sel = 4'b0001; stb = 1'b1; cyc = 1'b1;
    ack_seq[0] = ack;
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      ack_seq[i] = ack;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("ack_toggle", {58'b0, ack_seq}, 64'b101010);
    rd(2'd1, 32'h0000_0030);

    // Asynchronous reset in the middle of a data bit
    wr(2'd3, 32'h0000_0002, 4'b0001);
    k = 0;
    while (tx && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("frame_began", {63'b0, tx}, 64'd0);
    repeat (10) @(posedge clk);
    #3;
    check("pre_rst_tx", {63'b0, tx}, 64'd0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", {63'b0, tx}, 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(2'd1, 32'h0000_0002);
    stay = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      if (!tx) stay = 1'b0;
    end
    check("no_frame_after_rst", {63'b0, stay}, 64'd1);

    repeat (5) @(posedge clk);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("rx_q_empty", 64'(rx_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
